// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
// Imported by fetch_fifo and instruction_fetch_unit.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO of {pc, instr} entries with a combinational head view.
// Flush has priority over push and pop; DEPTH must be a power of two.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Storage needs no reset: entries are only visible while count is non-zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && !flush && (tail_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + PTR_W'(1);
            if (pop)  head_next = head_reg + PTR_W'(1);
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem_reg[head_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, RUN/HALT control, redirect handling and the fetch queue to decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic            fetch_fault
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    ifu_state_e      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            push, pop;
    logic            fq_full, fq_empty;
    logic [CNT_W-1:0] fq_count;
    fetch_entry_t    fq_head, fq_wdata;

    assign pop      = id_valid && id_ready;
    assign push     = (state_reg == RUN) && !redirect_valid && (!fq_full || pop);
    assign fq_wdata = '{pc: pc_reg, instr: imem_rdata};

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (fq_wdata),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count),
        .head  (fq_head)
    );

    // Any redirect lands on its target; alignment alone decides RUN vs HALT.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            state_next = (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
        end else if (push) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_reg, perf_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (push) perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if ((state_reg == RUN) && !redirect_valid && !push)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_stall_cnt = perf_stall_reg;
`endif

    assign imem_addr   = pc_reg;
    assign id_valid    = (fq_count != '0);
    assign id_instr    = fq_empty ? INSTR_NOP : fq_head.instr;
    assign id_pc       = fq_empty ? '0 : fq_head.pc;
    assign fetch_fault = (state_reg == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0033;
            32'h4:   return 32'h4000_0033;
            32'h8:   return 32'h0000_6033;
            32'h24:  return 32'h0000_0063;
            default: return {a[15:0], 16'h0013};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_pc", id_pc, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming from reset with decode always ready
        rst_n = 1'b1;
        tick();
        check("s_valid0", {31'b0, id_valid}, 32'h1);
        check("s_pc0", id_pc, 32'h0);
        check("s_instr0", id_instr, 32'h0000_0033);
        tick();
        check("s_pc4", id_pc, 32'h4);
        check("s_instr4", id_instr, 32'h4000_0033);
        tick();
        check("s_pc8", id_pc, 32'h8);
        check("s_instr8", id_instr, 32'h0000_6033);

        // Back-pressure from reset: two pushes then freeze
        rst_n = 1'b0;
        id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("bp_addr1", imem_addr, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_addr", imem_addr, 32'h8);
        end
        check("bp_valid", {31'b0, id_valid}, 32'h1);
        check("bp_head", id_pc, 32'h0);
        id_ready = 1'b1;
        tick();
        check("bp_pc4", id_pc, 32'h4);
        tick();
        check("bp_pc8", id_pc, 32'h8);
        check("bp_valid8", {31'b0, id_valid}, 32'h1);

        // Redirect with full queue and a concurrent pop
        redirect_valid = 1'b1;
        redirect_pc = 32'h24;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid", {31'b0, id_valid}, 32'h0);
        check("rd_addr", imem_addr, 32'h24);
        tick();
        check("rd_pc", id_pc, 32'h24);
        check("rd_instr", id_instr, 32'h0000_0063);

        // Misaligned target halts fetch
        redirect_valid = 1'b1;
        redirect_pc = 32'h1E;
        tick();
        redirect_valid = 1'b0;
        check("h_fault", {31'b0, fetch_fault}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("h_valid", {31'b0, id_valid}, 32'h0);
            check("h_addr", imem_addr, 32'h1E);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check("r_fault", {31'b0, fetch_fault}, 32'h0);
        check("r_addr", imem_addr, 32'h10);
        tick();
        check("r_pc", id_pc, 32'h10);
        check("r_instr", id_instr, 32'h0010_0013);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("w_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("w_pc_top", id_pc, 32'hFFFF_FFFC);
        check("w_addr0", imem_addr, 32'h0);
        tick();
        check("w_pc0", id_pc, 32'h0);
        check("w_instr0", id_instr, 32'h0000_0033);

        // Asynchronous reset with a full queue
        id_ready = 1'b0;
        tick();
        tick();
        check("ar_full", {31'b0, id_valid}, 32'h1);
        check("ar_addr8", imem_addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, id_valid}, 32'h0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_instr", id_instr, 32'h0000_0013);
`ifdef IFU_PERF_CNT_EN
        check("ar_pfetch", perf_fetch_cnt, 32'h0);
        check("ar_pstall", perf_stall_cnt, 32'h0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
